// File: rtl/drlp_img_loader_if.sv
// ============================================================================
// Module      : drlp_img_loader_if
// Description : Pixel stream (valid/ready) and image-buffer write bus.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface drlp_img_loader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int LANES      = 6
);
   logic                        px_valid;
   logic [DATA_WIDTH-1:0]       px_data;
   logic                        px_ready;
   logic                        wr_en;
   logic [ADDR_WIDTH-1:0]       wr_addr;
   logic [DATA_WIDTH*LANES-1:0] wr_data;

   // master = the loader; slave = pixel source plus buffer
   modport master (
      input  px_valid, px_data,
      output px_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output px_valid, px_data,
      input  px_ready, wr_en, wr_addr, wr_data
   );
endinterface

`default_nettype wire

// File: rtl/drlp_img_loader.sv
// ============================================================================
// Module      : drlp_img_loader
// Description : Packs LANES pixels per buffer word and writes one job of words.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module drlp_img_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int LANES      = 6
) (
   input  wire logic                  i_clk,
   input  wire logic                  i_rst,
   input  wire logic                  i_start,
   input  wire logic                  i_abort,
   input  wire logic [ADDR_WIDTH-1:0] i_base_addr,
   input  wire logic [ADDR_WIDTH-1:0] i_num_words,
   drlp_img_loader_if.master          bus,
   output logic                       o_busy,
   output logic                       o_done
);
   localparam int WORD_W = DATA_WIDTH * LANES;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0]     c_LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [ADDR_WIDTH-1:0] c_ONE       = ADDR_WIDTH'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOAD = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_ready;
   logic                  w_busy;
   logic                  w_acc;
   logic                  w_word_end;
   logic                  w_job_end;
   logic [ADDR_WIDTH-1:0] w_words_inc;
   logic [WORD_W-1:0]     w_word;

   logic [LANE_W-1:0]     r_lane;
   logic [ADDR_WIDTH-1:0] r_words;
   logic [ADDR_WIDTH-1:0] r_num;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WORD_W-1:0]     r_pack;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [WORD_W-1:0]     r_wr_data;
   logic                  r_done;

   // Accept is derived from the state register directly so it never loops
   // back through the next-state logic.
   assign w_acc       = (r_state == S_LOAD) & ~i_abort & bus.px_valid;
   assign w_word_end  = w_acc & (r_lane == c_LAST_LANE);
   assign w_words_inc = r_words + c_ONE;
   assign w_job_end   = (w_words_inc == r_num);

   always_comb begin
      w_word = r_pack;
      w_word[(LANES-1)*DATA_WIDTH +: DATA_WIDTH] = bus.px_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && (i_num_words != '0)) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_busy  = 1'b1;
            w_ready = ~i_abort;
            if (i_abort)                      w_state_nxt = S_IDLE;
            else if (w_word_end && w_job_end) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lane    <= '0;
         r_words   <= '0;
         r_num     <= '0;
         r_addr    <= '0;
         r_pack    <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_done    <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         if (r_state == S_IDLE) begin
            if (i_start) begin
               if (i_num_words == '0) begin
                  r_done <= 1'b1;
               end else begin
                  r_num   <= i_num_words;
                  r_addr  <= i_base_addr;
                  r_words <= '0;
                  r_lane  <= '0;
               end
            end
         end else if (i_abort) begin
            r_lane <= '0;
         end else if (w_acc) begin
            for (int k = 0; k < LANES; k++) begin
               if (r_lane == LANE_W'(k)) r_pack[k*DATA_WIDTH +: DATA_WIDTH] <= bus.px_data;
            end
            if (w_word_end) begin
               r_lane    <= '0;
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_addr;
               r_wr_data <= w_word;
               r_addr    <= r_addr + c_ONE;
               r_words   <= w_words_inc;
               r_done    <= w_job_end;
            end else begin
               r_lane <= r_lane + LANE_W'(1);
            end
         end
      end
   end

   assign bus.px_ready = w_ready;
   assign bus.wr_en    = r_wr_en;
   assign bus.wr_addr  = r_wr_addr;
   assign bus.wr_data  = r_wr_data;
   assign o_busy       = w_busy;
   assign o_done       = r_done;
endmodule

`default_nettype wire

// File: tb/tb_drlp_img_loader.sv
// ============================================================================
// Module      : tb_drlp_img_loader
// Description : Directed table vectors, corner sequences and random jobs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_drlp_img_loader;
   localparam int DW = 8;
   localparam int AW = 12;
   localparam int LN = 6;

   typedef struct {
      logic [AW-1:0]    base;
      logic [AW-1:0]    num;
      bit               toggle;
      logic [AW-1:0]    a0;
      logic [DW*LN-1:0] d0;
      logic [AW-1:0]    a1;
      logic [DW*LN-1:0] d1;
   } vec_t;

   typedef struct {
      logic [AW-1:0]    a;
      logic [DW*LN-1:0] d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_start = 1'b0;
   logic          s_abort = 1'b0;
   logic [AW-1:0] s_base = '0;
   logic [AW-1:0] s_num = '0;
   logic          dut_busy;
   logic          dut_done;

   int n_checks = 0;
   int n_err    = 0;

   bit               m_busy;
   bit               m_acc;
   logic [AW-1:0]    m_base;
   int               m_num;
   int               m_words;
   logic [DW-1:0]    m_buf[$];
   logic             e_wr_en;
   logic             e_done;
   logic [AW-1:0]    e_addr;
   logic [DW*LN-1:0] e_data;
   wr_t              cap[$];
   int               n_done;
   vec_t             vecs[3];

   drlp_img_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN)) bus ();

   drlp_img_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(LN)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (s_start),
      .i_abort     (s_abort),
      .i_base_addr (s_base),
      .i_num_words (s_num),
      .bus         (bus),
      .o_busy      (dut_busy),
      .o_done      (dut_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_acc   = 1'b0;
      m_words = 0;
      m_buf.delete();
      e_wr_en = 1'b0;
      e_done  = 1'b0;
      e_addr  = '0;
      e_data  = '0;
   endtask

   // One clock: called at posedge+1 with inputs already driven.
   task automatic cyc();
      logic exp_ready;
      #2;
      exp_ready = m_busy && !s_abort;
      chk("px_ready", bus.px_ready, exp_ready);
      m_acc   = exp_ready && bus.px_valid;
      e_wr_en = 1'b0;
      e_done  = 1'b0;
      if (!m_busy) begin
         if (s_start) begin
            if (s_num == 0) e_done = 1'b1;
            else begin
               m_busy  = 1'b1;
               m_base  = s_base;
               m_num   = s_num;
               m_words = 0;
               m_buf.delete();
            end
         end
      end else if (s_abort) begin
         m_busy = 1'b0;
         m_buf.delete();
      end else if (m_acc) begin
         m_buf.push_back(bus.px_data);
         if (m_buf.size() == LN) begin
            e_wr_en = 1'b1;
            e_addr  = AW'((int'(m_base) + m_words) % (1 << AW));
            for (int k = 0; k < LN; k++) e_data[k*DW +: DW] = m_buf[k];
            m_buf.delete();
            m_words++;
            if (m_words == m_num) begin
               m_busy = 1'b0;
               e_done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("busy", dut_busy, m_busy);
      chk("wr_en", bus.wr_en, e_wr_en);
      chk("done", dut_done, e_done);
      chk("wr_addr", bus.wr_addr, e_addr);
      chk("wr_data", bus.wr_data, e_data);
      if (bus.wr_en) cap.push_back('{a: bus.wr_addr, d: bus.wr_data});
      if (dut_done) n_done++;
   endtask

   task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] num);
      s_start = 1'b1;
      s_base  = base;
      s_num   = num;
      cyc();
      s_start = 1'b0;
   endtask

   task automatic send_pixels(input int n, input int first, input bit toggle);
      int idx = 0;
      for (int c = 0; c < 200 && idx < n; c++) begin
         bus.px_valid = toggle ? (c % 2 == 0) : 1'b1;
         bus.px_data  = DW'(first + idx);
         cyc();
         if (m_acc) idx++;
      end
      bus.px_valid = 1'b0;
      if (idx < n) chk("pixel_budget", 64'(idx), 64'(n));
   endtask

   task automatic flush(input int n);
      bus.px_valid = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      bus.px_valid = 1'b0;
      bus.px_data  = '0;
      model_reset();
      vecs[0] = '{base: 12'h010, num: 12'd2, toggle: 1'b0, a0: 12'h010,
                  d0: 48'h060504030201, a1: 12'h011, d1: 48'h0C0B0A090807};
      vecs[1] = '{base: 12'h010, num: 12'd2, toggle: 1'b1, a0: 12'h010,
                  d0: 48'h060504030201, a1: 12'h011, d1: 48'h0C0B0A090807};
      vecs[2] = '{base: 12'hFFF, num: 12'd2, toggle: 1'b0, a0: 12'hFFF,
                  d0: 48'h060504030201, a1: 12'h000, d1: 48'h0C0B0A090807};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_busy", dut_busy, 1'b0);
      chk("rst_ready", bus.px_ready, 1'b0);
      chk("rst_wr_en", bus.wr_en, 1'b0);
      chk("rst_done", dut_done, 1'b0);

      // Asynchronous reset asserted in the middle of the write cycle.
      start_job(12'h123, 12'd2);
      send_pixels(6, 8'h31, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      chk("async_wr_en", bus.wr_en, 1'b0);
      chk("async_addr", bus.wr_addr, 12'h000);
      chk("async_data", bus.wr_data, 48'h0);
      chk("async_busy", dut_busy, 1'b0);
      chk("async_ready", bus.px_ready, 1'b0);
      chk("async_done", dut_done, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush(1);

      foreach (vecs[i]) begin
         cap.delete();
         n_done = 0;
         start_job(vecs[i].base, vecs[i].num);
         send_pixels(12, 1, vecs[i].toggle);
         flush(2);
         chk("vec_nwrites", 64'(cap.size()), 64'd2);
         chk("vec_ndone", 64'(n_done), 64'd1);
         if (cap.size() == 2) begin
            chk("vec_a0", cap[0].a, vecs[i].a0);
            chk("vec_d0", cap[0].d, vecs[i].d0);
            chk("vec_a1", cap[1].a, vecs[i].a1);
            chk("vec_d1", cap[1].d, vecs[i].d1);
         end
      end

      // Abort after three pixels; the colliding pixel must not be taken.
      cap.delete();
      n_done = 0;
      start_job(12'h040, 12'd1);
      send_pixels(3, 8'hA1, 1'b0);
      s_abort      = 1'b1;
      bus.px_valid = 1'b1;
      bus.px_data  = 8'hA4;
      cyc();
      s_abort = 1'b0;
      flush(2);
      chk("abort_nwrites", 64'(cap.size()), 64'd0);
      chk("abort_ndone", 64'(n_done), 64'd0);
      start_job(12'h050, 12'd1);
      send_pixels(6, 1, 1'b0);
      flush(2);
      chk("abort_restart_n", 64'(cap.size()), 64'd1);
      if (cap.size() == 1) begin
         chk("abort_restart_a", cap[0].a, 12'h050);
         chk("abort_restart_d", cap[0].d, 48'h060504030201);
      end

      // Empty job, then a start pulse while loading.
      cap.delete();
      n_done = 0;
      start_job(12'h007, 12'd0);
      flush(2);
      chk("empty_ndone", 64'(n_done), 64'd1);
      chk("empty_nwrites", 64'(cap.size()), 64'd0);
      n_done = 0;
      start_job(12'h200, 12'd1);
      send_pixels(2, 8'h11, 1'b0);
      s_start = 1'b1;
      s_base  = 12'h300;
      s_num   = 12'd5;
      bus.px_valid = 1'b1;
      bus.px_data  = 8'h13;
      cyc();
      s_start = 1'b0;
      send_pixels(3, 8'h14, 1'b0);
      flush(2);
      chk("ign_start_n", 64'(cap.size()), 64'd1);
      chk("ign_start_done", 64'(n_done), 64'd1);
      if (cap.size() == 1) begin
         chk("ign_start_a", cap[0].a, 12'h200);
         chk("ign_start_d", cap[0].d, 48'h161514131211);
      end

      // Random jobs against the reference model.
      for (int j = 0; j < 40; j++) begin
         start_job(AW'($urandom), AW'($urandom_range(0, 3)));
         for (int c = 0; c < 300 && m_busy; c++) begin
            bus.px_valid = ($urandom_range(0, 3) != 0);
            bus.px_data  = DW'($urandom);
            s_abort      = ($urandom_range(0, 59) == 0);
            s_start      = ($urandom_range(0, 9) == 0);
            s_base       = AW'($urandom);
            s_num        = AW'($urandom);
            cyc();
         end
         s_abort = 1'b0;
         s_start = 1'b0;
         flush(2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

`default_nettype wire
